// File: rtl/id_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_pkg
// Description : Shared encodings for the 16-bit four-instruction pipeline
//               decode stage: opcodes, ALUOP codes, CC bit positions and the
//               branch-shadow FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package id_pkg;

  localparam logic [3:0] OPC_BR  = 4'b0000;
  localparam logic [3:0] OPC_ADD = 4'b0001;
  localparam logic [3:0] OPC_LDW = 4'b0110;
  localparam logic [3:0] OPC_STW = 4'b0111;

  localparam logic [1:0] ALU_BR  = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_LDW = 2'b10;
  localparam logic [1:0] ALU_STW = 2'b11;

  // Bit positions inside the {N,Z,P} condition-code vector
  localparam int CC_N = 2;
  localparam int CC_Z = 1;
  localparam int CC_P = 0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SHADOW = 1'b1
  } id_state_e;

  // Opcode to ALUOP; unknown opcodes map to BR but are never issued
  function automatic logic [1:0] opc_to_aluop(input logic [3:0] opc);
    logic [1:0] res;
    res = ALU_BR;
    case (opc)
      OPC_ADD: res = ALU_ADD;
      OPC_LDW: res = ALU_LDW;
      OPC_STW: res = ALU_STW;
      default: res = ALU_BR;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_p.sv
`default_nettype none
// ============================================================================
// Module      : regfile_p
// Description : 8 x DW register file, two asynchronous read ports, one write
//               port with write-through to both read ports, async clear.
// Ports       : clk_i, rst_i      clock / async active-high reset
//               ra1_i, ra2_i      read addresses; rd1_o, rd2_o read data
//               we_i, wa_i, wd_i  write enable / address / data
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_p #(
  parameter int unsigned DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [2:0]    ra1_i,
  input  logic [2:0]    ra2_i,
  output logic [DW-1:0] rd1_o,
  output logic [DW-1:0] rd2_o,
  input  logic          we_i,
  input  logic [2:0]    wa_i,
  input  logic [DW-1:0] wd_i
);

  logic [DW-1:0] regs_q [8];

  for (genvar g = 0; g < 8; g++) begin : g_reg
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        regs_q[g] <= '0;
      end else if (we_i && (wa_i == 3'(g))) begin
        regs_q[g] <= wd_i;
      end
    end
  end

  // A same-cycle write to the addressed register is visible immediately
  assign rd1_o = (we_i && (wa_i == ra1_i)) ? wd_i : regs_q[ra1_i];
  assign rd2_o = (we_i && (wa_i == ra2_i)) ? wd_i : regs_q[ra2_i];

endmodule
`default_nettype wire

// File: rtl/id_stage_p.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_p
// Description : Decode stage. Reads the register file, forwards from EX/MEM
//               or stalls on hazards, resolves branches against CC, and
//               drives a registered ID/EX latch with valid/ready handshake.
//               After a taken branch, BR_SHADOW fetches are squashed.
// Ports       : clk_i, rst_i                       clock / async reset
//               ir_i, ir_valid_i, pc_in_i          incoming instruction
//               id_ready_o                         decode accepts IR (comb)
//               ex_ready_i                         AGEX accepts latch
//               ex_*/mem_*                         in-flight producers
//               wb_enable_i, wb_dr_i, wb_result_i  register write port
//               cc_i                               {N,Z,P}
//               id_valid_o .. pc_out_o, branch_o   registered ID/EX latch
// Revision    : 1.0 - initial release
// ============================================================================
module id_stage_p
  import id_pkg::*;
#(
  parameter int unsigned DW        = 16,
  parameter bit          FWD_EN    = 1'b1,
  parameter int unsigned BR_SHADOW = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [15:0]   ir_i,
  input  logic          ir_valid_i,
  input  logic [15:0]   pc_in_i,
  output logic          id_ready_o,
  input  logic          ex_ready_i,
  input  logic          ex_valid_i,
  input  logic          mem_valid_i,
  input  logic [1:0]    ex_op_i,
  input  logic [1:0]    mem_op_i,
  input  logic [2:0]    ex_dr_i,
  input  logic [2:0]    mem_dr_i,
  input  logic [DW-1:0] ex_result_i,
  input  logic [DW-1:0] mem_result_i,
  input  logic          wb_enable_i,
  input  logic [2:0]    wb_dr_i,
  input  logic [DW-1:0] wb_result_i,
  input  logic [2:0]    cc_i,
  output logic          id_valid_o,
  output logic [1:0]    aluop_o,
  output logic [2:0]    dr_o,
  output logic [DW-1:0] operand1_o,
  output logic [DW-1:0] operand2_o,
  output logic [DW-1:0] pc_offset_o,
  output logic [DW-1:0] mem_offset_o,
  output logic [15:0]   pc_out_o,
  output logic          branch_o
);

  localparam logic [2:0] SHADOW_LEN = 3'(BR_SHADOW);

  // ---------------- decode ----------------
  logic [3:0]    opc;
  logic          is_br, is_add, is_ldw, is_stw, issuable;
  logic [2:0]    sr1, sr2;
  logic          use1, use2;
  logic          taken;
  logic [DW-1:0] rf1, rf2, src1, src2;

  assign opc      = ir_i[15:12];
  assign is_br    = (opc == OPC_BR);
  assign is_add   = (opc == OPC_ADD);
  assign is_ldw   = (opc == OPC_LDW);
  assign is_stw   = (opc == OPC_STW);
  assign issuable = is_br | is_add | is_ldw | is_stw;

  assign sr1  = ir_i[8:6];
  assign sr2  = is_stw ? ir_i[11:9] : ir_i[2:0];
  assign use1 = is_add | is_ldw | is_stw;
  assign use2 = (is_add & ~ir_i[5]) | is_stw;

  assign taken = is_br & ((ir_i[11] & cc_i[CC_N]) |
                          (ir_i[10] & cc_i[CC_Z]) |
                          (ir_i[9]  & cc_i[CC_P]));

  regfile_p #(.DW(DW)) u_rf (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .ra1_i (sr1),
    .ra2_i (sr2),
    .rd1_o (rf1),
    .rd2_o (rf2),
    .we_i  (wb_enable_i),
    .wa_i  (wb_dr_i),
    .wd_i  (wb_result_i)
  );

  // ---------------- forwarding ----------------
  // Only an ADD in EX and an LDW in MEM have their result ready to bypass.
  logic ex_fwd, mem_fwd;
  assign ex_fwd  = FWD_EN & ex_valid_i  & (ex_op_i  == ALU_ADD);
  assign mem_fwd = FWD_EN & mem_valid_i & (mem_op_i == ALU_LDW);

  assign src1 = (ex_fwd  && (ex_dr_i  == sr1)) ? ex_result_i  :
                (mem_fwd && (mem_dr_i == sr1)) ? mem_result_i : rf1;
  assign src2 = (ex_fwd  && (ex_dr_i  == sr2)) ? ex_result_i  :
                (mem_fwd && (mem_dr_i == sr2)) ? mem_result_i : rf2;

  // ---------------- hazards / handshake ----------------
  id_state_e  state_q;
  logic [2:0] cnt_q;
  logic       id_valid_q;
  logic       match_ex, match_mem, ex_prod, mem_prod, hazard_raw, hazard;
  logic       latch_open, issue;

  assign match_ex  = (use1 && (sr1 == ex_dr_i))  || (use2 && (sr2 == ex_dr_i));
  assign match_mem = (use1 && (sr1 == mem_dr_i)) || (use2 && (sr2 == mem_dr_i));
  assign ex_prod   = ex_valid_i  & ((ex_op_i  == ALU_ADD) | (ex_op_i  == ALU_LDW));
  assign mem_prod  = mem_valid_i & ((mem_op_i == ALU_ADD) | (mem_op_i == ALU_LDW));

  // Load-use always stalls; without forwarding any in-flight producer stalls
  // until it reaches WB, where write-through supplies the value.
  assign hazard_raw = (ex_valid_i & (ex_op_i == ALU_LDW) & match_ex) |
                      (~FWD_EN & ((ex_prod & match_ex) | (mem_prod & match_mem)));
  assign hazard     = ir_valid_i & (state_q == ST_RUN) & hazard_raw;

  assign latch_open = ~id_valid_q | ex_ready_i;
  assign id_ready_o = (state_q == ST_SHADOW) ? 1'b1 : (~hazard & latch_open);
  assign issue      = (state_q == ST_RUN) & ir_valid_i & id_ready_o & issuable;

  // ---------------- latch next-state ----------------
  logic [1:0]    aluop_d;
  logic [DW-1:0] op1_d, op2_d, pcoff_d, memoff_d;

  assign aluop_d  = opc_to_aluop(opc);
  assign op1_d    = use1 ? src1 : '0;
  assign op2_d    = use2   ? src2 :
                    is_add ? {{(DW-5){ir_i[4]}}, ir_i[4:0]} : '0;
  assign pcoff_d  = {{(DW-9){ir_i[8]}}, ir_i[8:0]};
  assign memoff_d = {{(DW-6){ir_i[5]}}, ir_i[5:0]};

  logic          branch_q;
  logic [1:0]    aluop_q;
  logic [2:0]    dr_q;
  logic [DW-1:0] op1_q, op2_q, pcoff_q, memoff_q;
  logic [15:0]   pc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_valid_q <= 1'b0;
      branch_q   <= 1'b0;
      aluop_q    <= '0;
      dr_q       <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      pcoff_q    <= '0;
      memoff_q   <= '0;
      pc_q       <= '0;
    end else begin
      branch_q <= issue & taken;
      if (latch_open) begin
        id_valid_q <= issue;
        if (issue) begin
          aluop_q  <= aluop_d;
          dr_q     <= ir_i[11:9];
          op1_q    <= op1_d;
          op2_q    <= op2_d;
          pcoff_q  <= pcoff_d;
          memoff_q <= memoff_d;
          pc_q     <= pc_in_i;
        end
      end
    end
  end

  // ---------------- branch-shadow FSM ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (issue && taken) begin
            state_q <= ST_SHADOW;
            cnt_q   <= SHADOW_LEN;
          end
        end
        ST_SHADOW: begin
          if (cnt_q <= 3'd1) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign id_valid_o   = id_valid_q;
  assign branch_o     = branch_q;
  assign aluop_o      = aluop_q;
  assign dr_o         = dr_q;
  assign operand1_o   = op1_q;
  assign operand2_o   = op2_q;
  assign pc_offset_o  = pcoff_q;
  assign mem_offset_o = memoff_q;
  assign pc_out_o     = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_id_stage_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage_p
// Description : Self-checking bench for id_stage_p. One instance with
//               forwarding, one without; a scoreboard holds the expected
//               latch contents of every issued instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage_p;

  typedef struct packed {
    logic [1:0]  aluop;
    logic [2:0]  dr;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [15:0] pcoff;
    logic [15:0] memoff;
    logic [15:0] pc;
    logic        br;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir, pc_in;
  logic        ir_valid1, ir_valid0;
  logic        ex_ready, ex_valid, mem_valid;
  logic [1:0]  ex_op, mem_op;
  logic [2:0]  ex_dr, mem_dr;
  logic [15:0] ex_result, mem_result;
  logic        wb_enable;
  logic [2:0]  wb_dr;
  logic [15:0] wb_result;
  logic [2:0]  cc;

  logic        id_ready1, id_valid1, branch1;
  logic [1:0]  aluop1;
  logic [2:0]  dr1;
  logic [15:0] op1_1, op2_1, pcoff1, memoff1, pc_out1;

  logic        id_ready0, id_valid0, branch0;
  logic [1:0]  aluop0;
  logic [2:0]  dr0;
  logic [15:0] op1_0, op2_0, pcoff0, memoff0, pc_out0;

  exp_t q1[$];
  exp_t q0[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  id_stage_p #(.DW(16), .FWD_EN(1'b1), .BR_SHADOW(2)) u_dut_fwd (
    .clk_i(clk), .rst_i(rst), .ir_i(ir), .ir_valid_i(ir_valid1), .pc_in_i(pc_in),
    .id_ready_o(id_ready1), .ex_ready_i(ex_ready),
    .ex_valid_i(ex_valid), .mem_valid_i(mem_valid), .ex_op_i(ex_op), .mem_op_i(mem_op),
    .ex_dr_i(ex_dr), .mem_dr_i(mem_dr), .ex_result_i(ex_result), .mem_result_i(mem_result),
    .wb_enable_i(wb_enable), .wb_dr_i(wb_dr), .wb_result_i(wb_result), .cc_i(cc),
    .id_valid_o(id_valid1), .aluop_o(aluop1), .dr_o(dr1), .operand1_o(op1_1),
    .operand2_o(op2_1), .pc_offset_o(pcoff1), .mem_offset_o(memoff1),
    .pc_out_o(pc_out1), .branch_o(branch1)
  );

  id_stage_p #(.DW(16), .FWD_EN(1'b0), .BR_SHADOW(2)) u_dut_nofwd (
    .clk_i(clk), .rst_i(rst), .ir_i(ir), .ir_valid_i(ir_valid0), .pc_in_i(pc_in),
    .id_ready_o(id_ready0), .ex_ready_i(ex_ready),
    .ex_valid_i(ex_valid), .mem_valid_i(mem_valid), .ex_op_i(ex_op), .mem_op_i(mem_op),
    .ex_dr_i(ex_dr), .mem_dr_i(mem_dr), .ex_result_i(ex_result), .mem_result_i(mem_result),
    .wb_enable_i(wb_enable), .wb_dr_i(wb_dr), .wb_result_i(wb_result), .cc_i(cc),
    .id_valid_o(id_valid0), .aluop_o(aluop0), .dr_o(dr0), .operand1_o(op1_0),
    .operand2_o(op2_0), .pc_offset_o(pcoff0), .mem_offset_o(memoff0),
    .pc_out_o(pc_out0), .branch_o(branch0)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] aluop, input logic [2:0] dr,
                              input logic [15:0] op1, input logic [15:0] op2,
                              input logic [15:0] pcoff, input logic [15:0] memoff,
                              input logic [15:0] pc, input logic br);
    exp_t e;
    e.aluop = aluop; e.dr = dr; e.op1 = op1; e.op2 = op2;
    e.pcoff = pcoff; e.memoff = memoff; e.pc = pc; e.br = br;
    return e;
  endfunction

  task automatic compare_rec(input string pfx, input exp_t e,
                             input logic [1:0] aluop, input logic [2:0] dr,
                             input logic [15:0] op1, input logic [15:0] op2,
                             input logic [15:0] pcoff, input logic [15:0] memoff,
                             input logic [15:0] pc, input logic br);
    check_eq({pfx, "_aluop"},  {30'd0, aluop}, {30'd0, e.aluop});
    check_eq({pfx, "_dr"},     {29'd0, dr},    {29'd0, e.dr});
    check_eq({pfx, "_op1"},    {16'd0, op1},   {16'd0, e.op1});
    check_eq({pfx, "_op2"},    {16'd0, op2},   {16'd0, e.op2});
    check_eq({pfx, "_pcoff"},  {16'd0, pcoff}, {16'd0, e.pcoff});
    check_eq({pfx, "_memoff"}, {16'd0, memoff},{16'd0, e.memoff});
    check_eq({pfx, "_pc"},     {16'd0, pc},    {16'd0, e.pc});
    check_eq({pfx, "_branch"}, {31'd0, br},    {31'd0, e.br});
  endtask

  // Scoreboard: compare whenever the latch hands an instruction to AGEX
  always @(negedge clk) begin
    if (!rst && id_valid1 && ex_ready) begin
      if (q1.size() == 0) check_eq("fwd_unexpected_issue", {31'd0, id_valid1}, 32'd0);
      else compare_rec("fwd", q1.pop_front(), aluop1, dr1, op1_1, op2_1,
                       pcoff1, memoff1, pc_out1, branch1);
    end
    if (!rst && id_valid0 && ex_ready) begin
      if (q0.size() == 0) check_eq("nofwd_unexpected_issue", {31'd0, id_valid0}, 32'd0);
      else compare_rec("nofwd", q0.pop_front(), aluop0, dr0, op1_0, op2_0,
                       pcoff0, memoff0, pc_out0, branch0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_latch(input string pfx);
    check_eq({pfx, "_id_valid"}, {31'd0, id_valid1}, 32'd0);
    check_eq({pfx, "_branch"},   {31'd0, branch1},   32'd0);
    check_eq({pfx, "_aluop"},    {30'd0, aluop1},    32'd0);
    check_eq({pfx, "_dr"},       {29'd0, dr1},       32'd0);
    check_eq({pfx, "_op1"},      {16'd0, op1_1},     32'd0);
    check_eq({pfx, "_op2"},      {16'd0, op2_1},     32'd0);
    check_eq({pfx, "_pcoff"},    {16'd0, pcoff1},    32'd0);
    check_eq({pfx, "_memoff"},   {16'd0, memoff1},   32'd0);
    check_eq({pfx, "_pc"},       {16'd0, pc_out1},   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ir = '0; pc_in = '0; ir_valid1 = 1'b0; ir_valid0 = 1'b0;
    ex_ready = 1'b1; ex_valid = 1'b0; mem_valid = 1'b0; ex_op = '0; mem_op = '0;
    ex_dr = '0; mem_dr = '0; ex_result = '0; mem_result = '0;
    wb_enable = 1'b0; wb_dr = '0; wb_result = '0; cc = 3'b000;
    step(); step();

    // Reset state
    check_zero_latch("rst");
    check_eq("rst_ready", {31'd0, id_ready1}, 32'd1);
    rst = 1'b0;

    // ADD R1,R0,#5 with WB writing R0=3 in the same cycle
    ir = 16'h1225; pc_in = 16'h3000; ir_valid1 = 1'b1;
    wb_enable = 1'b1; wb_dr = 3'd0; wb_result = 16'd3;
    q1.push_back(mk(2'b01, 3'd1, 16'h0003, 16'h0005, 16'h0025, 16'hFFE5, 16'h3000, 1'b0));
    #1 check_eq("add_imm_ready", {31'd0, id_ready1}, 32'd1);
    step();
    ir_valid1 = 1'b0; wb_enable = 1'b0;
    #1 check_eq("add_imm_valid", {31'd0, id_valid1}, 32'd1);

    // EX holds ADD to R2 = 0x0010; ADD R3,R2,R2
    ex_valid = 1'b1; ex_op = 2'b01; ex_dr = 3'd2; ex_result = 16'h0010;
    ir = 16'h1682; pc_in = 16'h3002; ir_valid1 = 1'b1;
    q1.push_back(mk(2'b01, 3'd3, 16'h0010, 16'h0010, 16'h0082, 16'h0002, 16'h3002, 1'b0));
    #1 check_eq("fwd_ex_ready", {31'd0, id_ready1}, 32'd1);
    step();
    // Same instruction on the non-forwarding instance: stall until WB
    ir_valid1 = 1'b0; ir_valid0 = 1'b1;
    #1 check_eq("nofwd_stall_ex", {31'd0, id_ready0}, 32'd0);
    step();
    ex_valid = 1'b0; mem_valid = 1'b1; mem_op = 2'b01; mem_dr = 3'd2; mem_result = 16'h0010;
    #1 check_eq("nofwd_stall_mem", {31'd0, id_ready0}, 32'd0);
    step();
    mem_valid = 1'b0; wb_enable = 1'b1; wb_dr = 3'd2; wb_result = 16'h0010;
    q0.push_back(mk(2'b01, 3'd3, 16'h0010, 16'h0010, 16'h0082, 16'h0002, 16'h3002, 1'b0));
    #1 check_eq("nofwd_wb_ready", {31'd0, id_ready0}, 32'd1);
    step();
    ir_valid0 = 1'b0; wb_enable = 1'b0;

    // Load-use: EX holds LDW to R4; STW R4,R5,#1
    ex_valid = 1'b1; ex_op = 2'b10; ex_dr = 3'd4;
    ir = 16'h7941; pc_in = 16'h3004; ir_valid1 = 1'b1;
    #1 check_eq("ldw_stall", {31'd0, id_ready1}, 32'd0);
    step();
    ex_valid = 1'b0; mem_valid = 1'b1; mem_op = 2'b10; mem_dr = 3'd4; mem_result = 16'hBEEF;
    q1.push_back(mk(2'b11, 3'd4, 16'h0000, 16'hBEEF, 16'hFF41, 16'h0001, 16'h3004, 1'b0));
    #1 check_eq("ldw_bubble", {31'd0, id_valid1}, 32'd0);
    check_eq("ldw_ready", {31'd0, id_ready1}, 32'd1);
    step();
    ir_valid1 = 1'b0; mem_valid = 1'b0;

    // Taken BRz with CC=010: two following IRs squashed, third issues
    cc = 3'b010;
    ir = 16'h0405; pc_in = 16'h3010; ir_valid1 = 1'b1;
    q1.push_back(mk(2'b00, 3'd2, 16'h0000, 16'h0000, 16'h0005, 16'h0005, 16'h3010, 1'b1));
    #1 check_eq("br_ready", {31'd0, id_ready1}, 32'd1);
    step();
    ir = 16'h1C21; pc_in = 16'h3012;
    #1 check_eq("br_pulse", {31'd0, branch1}, 32'd1);
    check_eq("shadow_ready", {31'd0, id_ready1}, 32'd1);
    step();
    ir = 16'h1C21; pc_in = 16'h3014;
    #1 check_eq("br_pulse_end", {31'd0, branch1}, 32'd0);
    check_eq("shadow_drop1", {31'd0, id_valid1}, 32'd0);
    step();
    ir = 16'h1E22; pc_in = 16'h3016;
    q1.push_back(mk(2'b01, 3'd7, 16'h0003, 16'h0002, 16'h0022, 16'hFFE2, 16'h3016, 1'b0));
    #1 check_eq("shadow_drop2", {31'd0, id_valid1}, 32'd0);
    check_eq("shadow_exit_ready", {31'd0, id_ready1}, 32'd1);
    step();

    // Not-taken BRn: issues without shadow, next IR issues back-to-back
    ir = 16'h0805; pc_in = 16'h3020;
    q1.push_back(mk(2'b00, 3'd4, 16'h0000, 16'h0000, 16'h0005, 16'h0005, 16'h3020, 1'b0));
    step();
    ir = 16'h1225; pc_in = 16'h3022;
    q1.push_back(mk(2'b01, 3'd1, 16'h0003, 16'h0005, 16'h0025, 16'hFFE5, 16'h3022, 1'b0));
    #1 check_eq("nt_ready", {31'd0, id_ready1}, 32'd1);
    check_eq("nt_nobranch", {31'd0, branch1}, 32'd0);
    step();

    // Backpressure: latch holds while EX_READY=0 and IR changes
    ir = 16'h1225; pc_in = 16'h3030;
    q1.push_back(mk(2'b01, 3'd1, 16'h0003, 16'h0005, 16'h0025, 16'hFFE5, 16'h3030, 1'b0));
    step();
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ir = 16'(16'h1E22 + i); pc_in = 16'(16'h3032 + 2 * i); ir_valid1 = 1'b1;
      #1 check_eq("hold_ready", {31'd0, id_ready1}, 32'd0);
      check_eq("hold_dr", {29'd0, dr1}, 32'd1);
      check_eq("hold_op2", {16'd0, op2_1}, 32'h0005);
      check_eq("hold_pc", {16'd0, pc_out1}, 32'h3030);
      step();
    end
    ex_ready = 1'b1; ir_valid1 = 1'b0;
    #1 check_eq("hold_valid", {31'd0, id_valid1}, 32'd1);
    step();

    // Reset asserted in SHADOW with counter at 1
    ir = 16'h0405; pc_in = 16'h3040; ir_valid1 = 1'b1;
    q1.push_back(mk(2'b00, 3'd2, 16'h0000, 16'h0000, 16'h0005, 16'h0005, 16'h3040, 1'b1));
    step();
    ir_valid1 = 1'b0;
    step();
    rst = 1'b1;
    #1 check_zero_latch("async_rst");
    step();
    rst = 1'b0;
    ir = 16'h1225; pc_in = 16'h3050; ir_valid1 = 1'b1;
    q1.push_back(mk(2'b01, 3'd1, 16'h0000, 16'h0005, 16'h0025, 16'hFFE5, 16'h3050, 1'b0));
    #1 check_eq("post_rst_ready", {31'd0, id_ready1}, 32'd1);
    step();
    ir_valid1 = 1'b0;
    step(); step();

    check_eq("sb_fwd_empty", q1.size(), 32'd0);
    check_eq("sb_nofwd_empty", q0.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
